// File: rtl/decode_stage_v2.sv
// Second-generation decode stage: field decode, register read, registered ID/EX
// boundary with valid/ready, load-use interlock, multiplier scoreboard and flush.
module decode_stage_v2 #(
    parameter int XLEN     = 32,
    parameter int REG_ADDR = 5,
    parameter int MUL_LAT  = 5,
    parameter int IMM_BITS = 21
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     pc,
    input  logic [31:0]         instruction,
    input  logic                flush,
    output logic [REG_ADDR-1:0] src_reg1,
    output logic [REG_ADDR-1:0] src_reg2,
    input  logic [XLEN-1:0]     rin_reg1,
    input  logic [XLEN-1:0]     rin_reg2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     rout_reg1,
    output logic [XLEN-1:0]     rout_reg2,
    output logic [REG_ADDR-1:0] out_addr_reg1,
    output logic [REG_ADDR-1:0] out_addr_reg2,
    output logic [REG_ADDR-1:0] dest_reg,
    output logic [XLEN-1:0]     mimmediat,
    output logic [5:0]          op_code,
    output logic [5:0]          funct_code,
    output logic                regwrite,
    output logic                memtoreg,
    output logic                memread,
    output logic                memwrite,
    output logic                byteword,
    output logic                branch,
    output logic                alusrc,
    output logic                is_mult,
    output logic [XLEN-1:0]     jump_addr,
    output logic                is_jump
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LDB   = 6'h20;
    localparam logic [5:0] OP_LDW   = 6'h23;
    localparam logic [5:0] OP_STB   = 6'h28;
    localparam logic [5:0] OP_STW   = 6'h2B;
    localparam logic [5:0] FN_MUL   = 6'h18;

    localparam int NREG = 2 ** REG_ADDR;
    localparam int CW   = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] MUL_LAT_C = CW'(MUL_LAT);

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     r1;
        logic [XLEN-1:0]     r2;
        logic [XLEN-1:0]     imm;
        logic [REG_ADDR-1:0] a1;
        logic [REG_ADDR-1:0] a2;
        logic [REG_ADDR-1:0] dest;
        logic [5:0]          op;
        logic [5:0]          fn;
        logic                regwrite;
        logic                memtoreg;
        logic                memread;
        logic                memwrite;
        logic                byteword;
        logic                branch;
        logic                alusrc;
        logic                is_mult;
    } idex_t;

    idex_t         idex, nxt;
    logic [CW-1:0] cnt [NREG];

    logic [5:0] op;
    logic       is_rtype, is_load, is_store, is_beq;
    logic       uses1, uses2, wr, src1_live, src2_live;
    logic       load_use, mul_raw, mul_waw, hazard, adv, accept;

    assign op       = instruction[31:26];
    assign is_rtype = (op == OP_RTYPE);
    assign is_load  = (op == OP_LDB) || (op == OP_LDW);
    assign is_store = (op == OP_STB) || (op == OP_STW);
    assign is_beq   = (op == OP_BEQ);

    assign src_reg1 = instruction[25:21];
    assign src_reg2 = instruction[20:16];

    always_comb begin
        // NOTE: assigning the whole struct first means no field is left unassigned on any path, so no latch.
        nxt          = '0;
        nxt.pc       = pc;
        nxt.r1       = rin_reg1;
        nxt.r2       = rin_reg2;
        nxt.imm      = {{(XLEN-IMM_BITS){instruction[IMM_BITS-1]}}, instruction[IMM_BITS-1:0]};
        nxt.a1       = src_reg1;
        nxt.a2       = src_reg2;
        nxt.dest     = (is_load || is_store) ? instruction[20:16] : instruction[15:11];
        nxt.op       = op;
        nxt.fn       = instruction[5:0];
        nxt.regwrite = is_rtype || is_load;
        nxt.memtoreg = is_load;
        nxt.memread  = is_load;
        nxt.memwrite = is_store;
        nxt.byteword = (op == OP_LDW) || (op == OP_STW);
        nxt.branch   = is_beq;
        nxt.alusrc   = is_load || is_store;
        nxt.is_mult  = is_rtype && (instruction[5:0] == FN_MUL);
    end

    assign uses1     = is_rtype || is_load || is_store || is_beq;
    assign uses2     = is_rtype || is_store || is_beq;
    assign wr        = nxt.regwrite && (nxt.dest != '0);
    assign src1_live = uses1 && (src_reg1 != '0);
    assign src2_live = uses2 && (src_reg2 != '0);

    // Only the instruction currently in ID/EX can be a load whose data is not yet ready.
    assign load_use = out_valid && idex.memread &&
                      ((src1_live && (idex.dest == src_reg1)) ||
                       (src2_live && (idex.dest == src_reg2)));
    assign mul_raw  = (src1_live && (cnt[src_reg1] != '0)) ||
                      (src2_live && (cnt[src_reg2] != '0));
    assign mul_waw  = wr && (cnt[nxt.dest] != '0);
    assign hazard   = load_use || mul_raw || mul_waw;

    assign adv      = !out_valid || out_ready;
    assign in_ready = flush || (adv && !hazard);
    assign accept   = in_valid && adv && !hazard && !flush;

    assign jump_addr = (pc & {4'hF, {(XLEN-4){1'b0}}}) | XLEN'({instruction[25:0], 2'b00});
    assign is_jump   = in_valid && in_ready && (op == OP_JUMP) && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            idex      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= accept;
            if (accept) idex <= nxt;
        end
    end

    // Counters run freely; a newly accepted MUL reloads its destination over the decrement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the counter array must be reset because stale counts would stall decode after reset.
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (accept && nxt.is_mult && (nxt.dest != '0) && (nxt.dest == REG_ADDR'(i)))
                    cnt[i] <= MUL_LAT_C;
                else if (cnt[i] != '0)
                    cnt[i] <= cnt[i] - CW'(1);
            end
        end
    end

    assign out_pc        = idex.pc;
    assign rout_reg1     = idex.r1;
    assign rout_reg2     = idex.r2;
    assign out_addr_reg1 = idex.a1;
    assign out_addr_reg2 = idex.a2;
    assign dest_reg      = idex.dest;
    assign mimmediat     = idex.imm;
    assign op_code       = idex.op;
    assign funct_code    = idex.fn;
    assign regwrite      = idex.regwrite;
    assign memtoreg      = idex.memtoreg;
    assign memread       = idex.memread;
    assign memwrite      = idex.memwrite;
    assign byteword      = idex.byteword;
    assign branch        = idex.branch;
    assign alusrc        = idex.alusrc;
    assign is_mult       = idex.is_mult;
endmodule

// File: tb/tb_decode_stage_v2.sv
// Directed bench for decode_stage_v2: expected ID/EX contents are queued when an
// instruction is accepted and compared when EX takes them.
module tb_decode_stage_v2;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LDB   = 6'h20;
    localparam logic [5:0] OP_LDW   = 6'h23;
    localparam logic [5:0] OP_STB   = 6'h28;
    localparam logic [5:0] OP_STW   = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_MUL   = 6'h18;

    logic        clk, reset, in_valid, flush, out_ready;
    logic [31:0] pc, instruction, rin_reg1, rin_reg2;
    logic        in_ready, out_valid, is_jump;
    logic [4:0]  src_reg1, src_reg2, out_addr_reg1, out_addr_reg2, dest_reg;
    logic [31:0] out_pc, rout_reg1, rout_reg2, mimmediat, jump_addr;
    logic [5:0]  op_code, funct_code;
    logic        regwrite, memtoreg, memread, memwrite, byteword, branch, alusrc, is_mult;

    typedef struct packed {
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  a1, a2, dest;
        logic [5:0]  op, fn;
        logic [7:0]  flags;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    decode_stage_v2 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .instruction(instruction), .flush(flush),
        .src_reg1(src_reg1), .src_reg2(src_reg2), .rin_reg1(rin_reg1), .rin_reg2(rin_reg2),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rout_reg1(rout_reg1), .rout_reg2(rout_reg2),
        .out_addr_reg1(out_addr_reg1), .out_addr_reg2(out_addr_reg2), .dest_reg(dest_reg),
        .mimmediat(mimmediat), .op_code(op_code), .funct_code(funct_code),
        .regwrite(regwrite), .memtoreg(memtoreg), .memread(memread), .memwrite(memwrite),
        .byteword(byteword), .branch(branch), .alusrc(alusrc), .is_mult(is_mult),
        .jump_addr(jump_addr), .is_jump(is_jump)
    );

    // Register bank stand-in: contents are a fixed function of the address.
    assign rin_reg1 = 32'h1000 + {27'b0, src_reg1};
    assign rin_reg2 = 32'h2000 + {27'b0, src_reg2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic exp_t model(input logic [31:0] p, input logic [31:0] ins);
        exp_t       e;
        logic [5:0] op;
        logic       ld, st;
        op      = ins[31:26];
        ld      = (op == OP_LDB) || (op == OP_LDW);
        st      = (op == OP_STB) || (op == OP_STW);
        e.pc    = p;
        e.a1    = ins[25:21];
        e.a2    = ins[20:16];
        e.r1    = 32'h1000 + {27'b0, ins[25:21]};
        e.r2    = 32'h2000 + {27'b0, ins[20:16]};
        e.imm   = {{11{ins[20]}}, ins[20:0]};
        e.dest  = (ld || st) ? ins[20:16] : ins[15:11];
        e.op    = op;
        e.fn    = ins[5:0];
        e.flags = {(op == OP_RTYPE) || ld, ld, ld, st, (op == OP_LDW) || (op == OP_STW),
                   op == OP_BEQ, ld || st, (op == OP_RTYPE) && (ins[5:0] == FN_MUL)};
        return e;
    endfunction

    // Present one instruction for one cycle; queue its expectation if it should be taken.
    task automatic issue(input logic [31:0] p, input logic [31:0] ins, input logic exp_rdy,
                         input string tag);
        in_valid    = 1'b1;
        pc          = p;
        instruction = ins;
        #1;
        check(tag, in_ready, exp_rdy);
        if (exp_rdy && !flush) sb_q.push_back(model(p, ins));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // EX side: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("ex_pc", out_pc, e.pc);
                check("ex_rdata", {rout_reg1, rout_reg2}, {e.r1, e.r2});
                check("ex_addrs", {out_addr_reg1, out_addr_reg2, dest_reg}, {e.a1, e.a2, e.dest});
                check("ex_imm", mimmediat, e.imm);
                check("ex_opfn", {op_code, funct_code}, {e.op, e.fn});
                check("ex_flags", {regwrite, memtoreg, memread, memwrite, byteword, branch, alusrc, is_mult},
                      e.flags);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] add_dep, add_ind;
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        pc = 32'h0; instruction = r_op(5'd7, 5'd9, 5'd3, FN_ADD);

        // Reset state and combinational pass-through while in reset
        #2;
        check("rst_src_regs", {src_reg1, src_reg2}, {5'd7, 5'd9});
        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_payload", {out_pc, rout_reg1, mimmediat, dest_reg, op_code, funct_code}, '0);
        check("rst_in_ready", in_ready, 1'b1);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        // Back-to-back ADDs
        for (int i = 0; i < 4; i++) begin
            issue(32'(i * 4), r_op(5'd1, 5'd2, 5'(10 + i), FN_ADD), 1'b1, "b2b_in_ready");
            check("b2b_out_valid", out_valid, 1'b1);
            check("b2b_out_pc", out_pc, 32'(i * 4));
        end
        idle();
        check("b2b_drain_bubble", out_valid, 1'b0);

        // Load-use: one bubble, then the consumer issues
        issue(32'h100, i_op(OP_LDW, 5'd1, 5'd3, 16'h0008), 1'b1, "lu_ldw_ready");
        issue(32'h104, r_op(5'd3, 5'd1, 5'd4, FN_ADD), 1'b0, "lu_stall_ready");
        check("lu_bubble", out_valid, 1'b0);
        issue(32'h104, r_op(5'd3, 5'd1, 5'd4, FN_ADD), 1'b1, "lu_release_ready");
        check("lu_add_pc", {31'b0, out_valid, out_pc}, {32'd1, 32'h104});
        // r0 as load destination never interlocks
        issue(32'h108, i_op(OP_LDB, 5'd1, 5'd0, 16'hFFF0), 1'b1, "lu_r0_ldb_ready");
        issue(32'h10C, r_op(5'd0, 5'd1, 5'd4, FN_ADD), 1'b1, "lu_r0_no_stall");
        idle();

        // MUL RAW: dependent ADD held MUL_LAT cycles
        add_dep = r_op(5'd5, 5'd2, 5'd7, FN_ADD);
        issue(32'h200, r_op(5'd1, 5'd2, 5'd5, FN_MUL), 1'b1, "mul_ready");
        for (int i = 0; i < 5; i++) begin
            issue(32'h204, add_dep, 1'b0, "mul_raw_stall");
            check("mul_raw_bubble", out_valid, 1'b0);
        end
        issue(32'h204, add_dep, 1'b1, "mul_raw_release");
        check("mul_raw_pc", out_pc, 32'h204);

        // New MUL, independent ADD, then flush during a load-use stall
        issue(32'h208, r_op(5'd1, 5'd2, 5'd5, FN_MUL), 1'b1, "mul2_ready");
        add_ind = r_op(5'd1, 5'd2, 5'd6, FN_ADD);
        issue(32'h20C, add_ind, 1'b1, "mul_indep_no_stall");
        issue(32'h210, i_op(OP_LDW, 5'd1, 5'd8, 16'h0004), 1'b1, "fl_ldw_ready");
        in_valid = 1'b1; pc = 32'h214; instruction = r_op(5'd8, 5'd1, 5'd9, FN_ADD);
        #1;
        check("fl_pre_stall", in_ready, 1'b0);
        flush = 1'b1;
        issue(32'h214, r_op(5'd8, 5'd1, 5'd9, FN_ADD), 1'b1, "fl_in_ready");
        flush = 1'b0;
        check("fl_out_valid", out_valid, 1'b0);
        // cnt[r5] was 5 at 0x20C accept and kept falling: 2 stalls remain
        issue(32'h218, r_op(5'd5, 5'd1, 5'd10, FN_ADD), 1'b0, "fl_sb_stall1");
        issue(32'h218, r_op(5'd5, 5'd1, 5'd10, FN_ADD), 1'b0, "fl_sb_stall2");
        issue(32'h218, r_op(5'd5, 5'd1, 5'd10, FN_ADD), 1'b1, "fl_sb_release");
        check("fl_sb_pc", out_pc, 32'h218);

        // Back-pressure: payload holds, in_ready low
        issue(32'h300, r_op(5'd1, 5'd2, 5'd12, FN_ADD), 1'b1, "bp_first_ready");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(32'h304, i_op(OP_STW, 5'd2, 5'd3, 16'h8000), 1'b0, "bp_in_ready");
            check("bp_hold", {31'b0, out_valid, out_pc, rout_reg1}, {32'd1, 32'h300, 32'h1001});
        end
        out_ready = 1'b1;
        issue(32'h304, i_op(OP_STW, 5'd2, 5'd3, 16'h8000), 1'b1, "bp_release");
        check("bp_next_pc", out_pc, 32'h304);

        // Jump: suppressed under flush, then taken
        flush = 1'b1; in_valid = 1'b1; pc = 32'h40000010; instruction = {OP_JUMP, 26'h100};
        #1;
        check("j_flush_is_jump", is_jump, 1'b0);
        issue(32'h40000010, {OP_JUMP, 26'h100}, 1'b1, "j_flush_ready");
        flush = 1'b0;
        check("j_flush_out_valid", out_valid, 1'b0);
        #1;
        check("j_addr", jump_addr, 32'h40000400);
        check("j_is_jump", is_jump, 1'b1);
        issue(32'h40000010, {OP_JUMP, 26'h100}, 1'b1, "j_ready");
        issue(32'h40000014, i_op(OP_BEQ, 5'd1, 5'd2, 16'hFFFE), 1'b1, "beq_ready");

        // Reset mid-stream with a MUL in flight
        issue(32'h500, r_op(5'd1, 5'd2, 5'd5, FN_MUL), 1'b1, "rst2_mul_ready");
        in_valid = 1'b1; pc = 32'h504; instruction = r_op(5'd5, 5'd1, 5'd11, FN_ADD);
        #1;
        check("rst2_pre_stall", in_ready, 1'b0);
        #4;
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst2_outputs", {31'b0, out_valid, out_pc, mimmediat, dest_reg, op_code},
              {32'd0, 32'd0, 32'd0, 5'd0, 6'd0});
        check("rst2_in_ready", in_ready, 1'b1);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        issue(32'h504, r_op(5'd5, 5'd1, 5'd11, FN_ADD), 1'b1, "rst2_no_stall");
        check("rst2_issue", {31'b0, out_valid, out_pc}, {32'd1, 32'h504});

        idle();
        idle();
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
